// File: rtl/pc_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives instruction-memory requests and fills IF/ID.
// Redirects flush IF/ID and the hold buffer. An unanswered request is drained before fetching resumes.
//
// state | meaning
// BOOT  | one idle cycle after reset, no request
// FETCH | request at pc; accepted data goes to IF/ID, or to the hold buffer when stalled
// HOLD  | accepted data parked while stalled, no request
// DRAIN | waiting out a request abandoned by a redirect
module pc_fetch_stage #(
  parameter int                ADDR_W   = 32,
  parameter int                INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_target,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [ADDR_W-1:0]  pc,
  output logic               if_id_valid,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [ADDR_W-1:0]  if_id_pc,
  output logic [ADDR_W-1:0]  if_id_pc_plus4
);

  typedef enum logic [1:0] {S_BOOT, S_FETCH, S_HOLD, S_DRAIN} state_t;

  localparam logic [ADDR_W-1:0] FOUR = ADDR_W'(4);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [ADDR_W-1:0]   drain_addr_q, drain_addr_d;
  logic                if_id_valid_q, if_id_valid_d;
  logic [INSTR_W-1:0]  if_id_instr_q, if_id_instr_d;
  logic [ADDR_W-1:0]   if_id_pc_q, if_id_pc_d;
  logic [ADDR_W-1:0]   if_id_pc4_q, if_id_pc4_d;
  logic                hold_valid_q, hold_valid_d;
  logic [INSTR_W-1:0]  hold_instr_q, hold_instr_d;
  logic [ADDR_W-1:0]   hold_pc_q, hold_pc_d;
  logic [ADDR_W-1:0]   redir_pc;
  logic [ADDR_W-1:0]   pc_plus4;

  assign redir_pc = {redirect_target[ADDR_W-1:2], 2'b00};
  assign pc_plus4 = pc_q + FOUR;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    drain_addr_d  = drain_addr_q;
    if_id_valid_d = if_id_valid_q;
    if_id_instr_d = if_id_instr_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_pc4_d   = if_id_pc4_q;
    hold_valid_d  = hold_valid_q;
    hold_instr_d  = hold_instr_q;
    hold_pc_d     = hold_pc_q;

    if (redirect_valid) begin
      if_id_valid_d = 1'b0;
      hold_valid_d  = 1'b0;
      pc_d          = redir_pc;
    end

    case (state_q)
      S_BOOT: state_d = S_FETCH;
      S_FETCH: begin
        if (redirect_valid) begin
          if (!imem_ready) begin
            state_d      = S_DRAIN;
            drain_addr_d = pc_q;
          end
        end else if (imem_ready) begin
          pc_d = pc_plus4;
          if (stall) begin
            hold_valid_d = 1'b1;
            hold_instr_d = imem_rdata;
            hold_pc_d    = pc_q;
            state_d      = S_HOLD;
          end else begin
            if_id_valid_d = 1'b1;
            if_id_instr_d = imem_rdata;
            if_id_pc_d    = pc_q;
            if_id_pc4_d   = pc_plus4;
          end
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          state_d = S_FETCH;
        end else if (!stall) begin
          if_id_valid_d = hold_valid_q;
          if_id_instr_d = hold_instr_q;
          if_id_pc_d    = hold_pc_q;
          if_id_pc4_d   = hold_pc_q + FOUR;
          hold_valid_d  = 1'b0;
          state_d       = S_FETCH;
        end
      end
      S_DRAIN: begin
        // Returning data belongs to the abandoned path and is dropped.
        if (imem_ready) state_d = S_FETCH;
      end
      default: state_d = S_BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_BOOT;
      pc_q          <= RESET_PC;
      drain_addr_q  <= '0;
      if_id_valid_q <= 1'b0;
      if_id_instr_q <= '0;
      if_id_pc_q    <= '0;
      if_id_pc4_q   <= '0;
      hold_valid_q  <= 1'b0;
      hold_instr_q  <= '0;
      hold_pc_q     <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      drain_addr_q  <= drain_addr_d;
      if_id_valid_q <= if_id_valid_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_pc4_q   <= if_id_pc4_d;
      hold_valid_q  <= hold_valid_d;
      hold_instr_q  <= hold_instr_d;
      hold_pc_q     <= hold_pc_d;
    end
  end

  assign imem_req       = (state_q == S_FETCH) || (state_q == S_DRAIN);
  assign imem_addr      = (state_q == S_DRAIN) ? drain_addr_q : pc_q;
  assign pc             = pc_q;
  assign if_id_valid    = if_id_valid_q;
  assign if_id_instr    = if_id_instr_q;
  assign if_id_pc       = if_id_pc_q;
  assign if_id_pc_plus4 = if_id_pc4_q;

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Scoreboard bench for pc_fetch_stage: expected fetch addresses and IF/ID entries are queued by the
// stimulus; a negedge monitor pops them on each accepted request and each IF/ID hand-off.
module tb_pc_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic        if_id_valid;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc_plus4;
  logic [31:0] rdata_off;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
  } ifid_t;

  logic [31:0] exp_fetch[$];
  ifid_t       exp_ifid[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  pc_fetch_stage #(.ADDR_W(32), .INSTR_W(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .pc(pc), .if_id_valid(if_id_valid), .if_id_instr(if_id_instr),
    .if_id_pc(if_id_pc), .if_id_pc_plus4(if_id_pc_plus4)
  );

  always #5 clk = ~clk;

  // Memory model: instruction word is its address plus a per-phase offset.
  assign imem_rdata = imem_addr + rdata_off;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_ifid(input logic [31:0] instr, input logic [31:0] a);
    ifid_t e;
    e.instr = instr;
    e.pc    = a;
    e.pc4   = a + 32'd4;
    exp_ifid.push_back(e);
  endtask

  // Downstream consumes IF/ID whenever it is valid, not stalled and not being flushed.
  always @(negedge clk) begin
    if (!rst) begin
      if (imem_req && imem_ready) begin
        if (exp_fetch.size() == 0) check("unexpected_fetch", {64'h0, imem_addr}, 96'hFFFFFFFF);
        else check("fetch_addr", {64'h0, imem_addr}, {64'h0, exp_fetch.pop_front()});
      end
      if (if_id_valid && !stall && !redirect_valid) begin
        if (exp_ifid.size() == 0) check("unexpected_ifid", {if_id_instr, if_id_pc, if_id_pc_plus4}, '1);
        else check("ifid", {if_id_instr, if_id_pc, if_id_pc_plus4}, exp_ifid.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
    imem_ready = 1'b1; rdata_off = '0;
    #1 rst = 1'b1;
    step(); step();
    check("rst_pc",    {64'h0, pc}, 96'h0);
    check("rst_req",   {95'h0, imem_req}, 96'h0);
    check("rst_valid", {95'h0, if_id_valid}, 96'h0);
    check("rst_ifid",  {if_id_instr, if_id_pc, if_id_pc_plus4}, 96'h0);

    // Boot cycle then back-to-back fetches 0,4,8,C
    rst = 1'b0;
    #1 check("boot_req", {95'h0, imem_req}, 96'h0);
    for (int i = 0; i < 4; i++) begin
      exp_fetch.push_back(32'(i * 4));
      push_ifid(32'(i * 4), 32'(i * 4));
    end
    step(); step(); step(); step();

    // Stall while 0x10 returns 0x20
    step(); stall = 1'b1; rdata_off = 32'h10; exp_fetch.push_back(32'h10);
    step(); rdata_off = '0;
    #1 check("hold_req", {95'h0, imem_req}, 96'h0);
    check("freeze1", {if_id_valid, if_id_instr, if_id_pc, if_id_pc_plus4}, {1'b1, 32'hC, 32'hC, 32'h10});
    step();
    #1 check("hold_req2", {95'h0, imem_req}, 96'h0);
    check("freeze2", {if_id_valid, if_id_instr, if_id_pc, if_id_pc_plus4}, {1'b1, 32'hC, 32'hC, 32'h10});
    step(); stall = 1'b0; push_ifid(32'h20, 32'h10);
    step(); exp_fetch.push_back(32'h14);

    // Redirect to 8, then redirect to 0x41 while 8 is outstanding
    step(); redirect_valid = 1'b1; redirect_target = 32'h8; exp_fetch.push_back(32'h18);
    step(); redirect_target = 32'h41; imem_ready = 1'b0;
    #1 check("drain_addr0", {64'h0, imem_addr}, 96'h8);
    check("flush_valid", {95'h0, if_id_valid}, 96'h0);
    step(); redirect_valid = 1'b0;
    #1 check("drain_addr1", {64'h0, imem_addr}, 96'h8);
    check("drain_req", {95'h0, imem_req}, 96'h1);
    step(); imem_ready = 1'b1; exp_fetch.push_back(32'h8);
    #1 check("drain_valid", {95'h0, if_id_valid}, 96'h0);
    step(); exp_fetch.push_back(32'h40);
    #1 check("post_drain_addr", {64'h0, imem_addr}, 96'h40);
    check("post_drain_valid", {95'h0, if_id_valid}, 96'h0);

    // Redirect and stall in the same cycle
    step(); stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h100; exp_fetch.push_back(32'h44);
    step(); stall = 1'b0; redirect_valid = 1'b0; exp_fetch.push_back(32'h100);
    #1 check("redir_stall_pc", {64'h0, pc}, 96'h100);
    check("redir_stall_valid", {95'h0, if_id_valid}, 96'h0);

    // Wrap from 0xFFFFFFFC; unaligned target is forced to word alignment
    step(); redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFF; exp_fetch.push_back(32'h104);
    step(); redirect_valid = 1'b0; exp_fetch.push_back(32'hFFFF_FFFC);
    #1 check("align_pc", {64'h0, pc}, 96'hFFFF_FFFC);
    step(); exp_fetch.push_back(32'h0);
    exp_ifid.push_back({32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0});
    #1 check("wrap_addr", {64'h0, imem_addr}, 96'h0);
    check("wrap_pc4", {64'h0, if_id_pc_plus4}, 96'h0);
    step(); exp_fetch.push_back(32'h4); push_ifid(32'h0, 32'h0);

    // Async reset in the middle of a drain
    step(); imem_ready = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h200;
    step(); redirect_valid = 1'b0;
    #1 check("pre_rst_req", {95'h0, imem_req}, 96'h1);
    check("pre_rst_addr", {64'h0, imem_addr}, 96'h8);
    #1 rst = 1'b1;
    #1 check("async_req", {95'h0, imem_req}, 96'h0);
    check("async_pc", {64'h0, pc}, 96'h0);
    check("async_valid", {95'h0, if_id_valid}, 96'h0);
    step(); imem_ready = 1'b1;
    step(); rst = 1'b0;
    #1 check("reboot_req", {95'h0, imem_req}, 96'h0);
    for (int i = 0; i < 3; i++) exp_fetch.push_back(32'(i * 4));
    push_ifid(32'h0, 32'h0);
    push_ifid(32'h4, 32'h4);
    step(); step(); step();
    step(); imem_ready = 1'b0; stall = 1'b1;
    step(); step();
    check("fetch_queue_empty", 96'(exp_fetch.size()), 96'h0);
    check("ifid_queue_empty", 96'(exp_ifid.size()), 96'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
